// File: rtl/pyc_sram_arb_pkg.sv
// Shared types and helpers for the pyc_sram request arbiter.
package pyc_sram_arb_pkg;

  // Arbitration mode: free round-robin or pinned to one requester.
  typedef enum logic [0:0] {
    StArb,
    StLocked
  } lock_st_e;

  // Rotate-priority pick over up to 16 requesters.
  // Returns {any_valid, index}; index is 0 when nothing is valid.
  function automatic logic [4:0] rr_pick(input logic [15:0] valid,
                                         input logic [3:0]  ptr,
                                         input int unsigned n);
    logic [4:0]  res;
    logic        found;
    int unsigned idx;
    logic [3:0]  idx4;
    res   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < 16; k++) begin
      idx  = (32'(ptr) + k) % n;
      idx4 = idx[3:0];
      if (!found && (k < n) && valid[idx4]) begin
        found = 1'b1;
        res   = {1'b1, idx4};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pyc_sram_arb_rr_pick.sv
// Combinational rotate-priority encoder: first valid index at or after ptr.
module pyc_rr_pick
  import pyc_sram_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  idx,
  output logic            any_valid
);

  logic [4:0] pick;

  // Widen to the helper's fixed 16-entry form and narrow the result back.
  always_comb begin
    pick      = rr_pick(16'(valid), 4'(ptr), NREQ);
    idx       = pick[IDW-1:0];
    any_valid = pick[4];
  end

endmodule

// File: rtl/pyc_sram_arb.sv
// Round-robin arbiter sharing one single-outstanding SRAM port among NREQ
// requesters, with optional locked bursts and response routing by owner.
module pyc_sram_arb
  import pyc_sram_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4,
  localparam int unsigned STRB_WIDTH = (DATA_WIDTH + 7) / 8,
  localparam int unsigned IDW        = $clog2(NREQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              s_req_valid,
  output logic [NREQ-1:0]              s_req_ready,
  input  logic [NREQ-1:0]              s_req_lock,
  input  logic [NREQ*ADDR_WIDTH-1:0]   s_req_addr,
  input  logic [NREQ-1:0]              s_req_write,
  input  logic [NREQ*DATA_WIDTH-1:0]   s_req_wdata,
  input  logic [NREQ*STRB_WIDTH-1:0]   s_req_wstrb,
  output logic [NREQ-1:0]              s_resp_valid,
  input  logic [NREQ-1:0]              s_resp_ready,
  output logic [DATA_WIDTH-1:0]        s_resp_rdata,
  output logic                         m_req_valid,
  input  logic                         m_req_ready,
  output logic [ADDR_WIDTH-1:0]        m_req_addr,
  output logic                         m_req_write,
  output logic [DATA_WIDTH-1:0]        m_req_wdata,
  output logic [STRB_WIDTH-1:0]        m_req_wstrb,
  input  logic                         m_resp_valid,
  output logic                         m_resp_ready,
  input  logic [DATA_WIDTH-1:0]        m_resp_rdata,
  output logic [IDW-1:0]               grant_id
);

  lock_st_e       lock_st_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] owner_q;
  logic [IDW-1:0] lock_id_q;
  logic [7:0]     beat_cnt_q;

  logic [IDW-1:0] rr_idx;
  logic           rr_any;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] next_ptr;
  logic [8:0]     beat_next;
  logic           fire;

  pyc_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .valid     (s_req_valid),
    .ptr       (rr_ptr_q),
    .idx       (rr_idx),
    .any_valid (rr_any)
  );

  // Select the granted requester and forward its request to the SRAM.
  always_comb begin
    sel         = (lock_st_q == StLocked) ? lock_id_q : rr_idx;
    // While locked, only the lock holder may drive the bus; others are masked.
    m_req_valid = rst_n & ((lock_st_q == StLocked) ? s_req_valid[lock_id_q] : rr_any);
    m_req_addr  = s_req_addr[32'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
    m_req_write = s_req_write[sel];
    m_req_wdata = s_req_wdata[32'(sel)*DATA_WIDTH +: DATA_WIDTH];
    m_req_wstrb = s_req_wstrb[32'(sel)*STRB_WIDTH +: STRB_WIDTH];
    grant_id    = rst_n ? sel : '0;
    fire        = m_req_valid & m_req_ready;
    next_ptr    = (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);
    beat_next   = {1'b0, beat_cnt_q} + 9'd1;
  end

  // Per-requester accept: only the selected, valid requester sees ready.
  always_comb begin
    s_req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      s_req_ready[i] = rst_n & (sel == IDW'(i)) & s_req_valid[i] & m_req_ready;
    end
  end

  // Route the SRAM response to the requester that issued the in-flight request.
  always_comb begin
    s_resp_valid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      s_resp_valid[i] = rst_n & m_resp_valid & (owner_q == IDW'(i));
    end
    m_resp_ready = rst_n & s_resp_ready[owner_q];
    s_resp_rdata = m_resp_rdata;
  end

  // Arbitration state: round-robin pointer, owner, and burst lock tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_st_q  <= StArb;
      lock_id_q  <= '0;
      beat_cnt_q <= '0;
    end else if (fire) begin
      owner_q  <= sel;
      rr_ptr_q <= next_ptr;
      // The MAX_BURST-th consecutive beat releases the lock regardless of request.
      if (s_req_lock[sel] && (32'(beat_next) < MAX_BURST)) begin
        lock_st_q  <= StLocked;
        lock_id_q  <= sel;
        beat_cnt_q <= beat_next[7:0];
      end else begin
        lock_st_q  <= StArb;
        beat_cnt_q <= '0;
      end
    end
  end

endmodule

// File: doc/pyc_sram_arb.md
Name: pyc_sram_arb

Overview:
- Round-robin arbiter sharing one single-outstanding request/response SRAM port (pyc_sram-style: one request in flight, read data 1 cycle after accept) among NREQ requesters.
- Routes each response back to the requester that issued the request.
- Supports optional locked bursts, so one requester can hold the grant for up to MAX_BURST back-to-back requests.
- Sits between core-side clients (fetch, load/store, DMA) and the shared SRAM instance.

Parameters:
- NREQ, 4, number of requesters (2..16).
- ADDR_WIDTH, 10, word address width.
- DATA_WIDTH, 32, data width.
- MAX_BURST, 4, maximum consecutive grants held under lock (1..256).
- Local constants: STRB_WIDTH = (DATA_WIDTH+7)/8; IDW = $clog2(NREQ).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low (sampled on posedge clk only).
- s_req_valid  in  NREQ  per-requester request valid.
- s_req_ready  out  NREQ  per-requester request accept.
- s_req_lock  in  NREQ  requester asks to keep the grant after this beat.
- s_req_addr  in  NREQ*ADDR_WIDTH  flattened addresses; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH].
- s_req_write  in  NREQ  write flag.
- s_req_wdata  in  NREQ*DATA_WIDTH  flattened write data.
- s_req_wstrb  in  NREQ*STRB_WIDTH  flattened byte strobes.
- s_resp_valid  out  NREQ  per-requester response valid.
- s_resp_ready  in  NREQ  per-requester response accept.
- s_resp_rdata  out  DATA_WIDTH  read data, broadcast; qualified by s_resp_valid.
- m_req_valid / m_req_ready / m_req_addr / m_req_write / m_req_wdata / m_req_wstrb  out/in/out/out/out/out  1/1/ADDR_WIDTH/1/DATA_WIDTH/STRB_WIDTH  to SRAM request port.
- m_resp_valid / m_resp_ready / m_resp_rdata  in/out/in  1/1/DATA_WIDTH  from SRAM response port.
- grant_id  out  IDW  requester currently selected (debug/perf).

Behaviour:
- Registered state:
  - rr_ptr (IDW): highest-priority index.
  - owner (IDW): issuer of the in-flight request.
  - lock_st, one of ARB or LOCKED.
  - lock_id (IDW).
  - beat_cnt (8b).
- Reset (rst_n=0 at posedge): rr_ptr=0, owner=0, lock_st=ARB, lock_id=0, beat_cnt=0. Outputs during and after reset until the first request: m_req_valid=0, s_req_ready=0, s_resp_valid=0, m_resp_ready=0, grant_id=0. Reset mid-transaction drops the in-flight response (the SRAM is reset on the same reset). Nothing is replayed.
- Selection (combinational):
  - In ARB: sel = first i with s_req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - In LOCKED: sel = lock_id. Other requesters are masked.
- Forwarding: m_req_valid = s_req_valid[sel] (0 if none valid). m_req_* fields are muxed from slice sel. s_req_ready[i] = (i==sel) & s_req_valid[i] & m_req_ready. All other bits are 0. grant_id = sel.
- No req_valid→req_ready combinational dependency other than through sel.
- Fire is m_req_valid & m_req_ready.
- On fire:
  - owner<=sel; rr_ptr<=(sel+1) mod NREQ.
  - If s_req_lock[sel] & beat_cnt+1 < MAX_BURST: lock_st<=LOCKED, lock_id<=sel, beat_cnt<=beat_cnt+1.
  - Otherwise: lock_st<=ARB, beat_cnt<=0.
- LOCKED exit:
  - LOCKED with lock_id not valid for a cycle: hold LOCKED; the bus idles. Lock is a promise by the requester.
  - A fire with s_req_lock=0 returns to ARB.
  - The MAX_BURST-th consecutive beat forces ARB regardless of lock.
- Response routing: s_resp_valid[i] = m_resp_valid & (i==owner). m_resp_ready = s_resp_ready[owner]. s_resp_rdata = m_resp_rdata.
- Simultaneous events:
  - A response to owner A and a new grant to B in the same cycle is legal; the SRAM accepts only when the response fires.
  - owner updates at the same edge the old response completes.
  - The response to the new request appears the next cycle with owner=B.
- Wrap: rr_ptr wraps NREQ-1 → 0. For non-power-of-two NREQ, values ≥ NREQ never occur.
- Latency: zero added cycles on the request path and the response path. Throughput is identical to a direct SRAM connection.

Decomposition:
- Package pyc_sram_arb_pkg holds the lock_st enum (ARB, LOCKED) and the function rr_pick(valid, ptr) returning the index.
- Natural sub-module: pyc_rr_pick, a combinational rotate-priority encoder (NREQ in, IDW out + any_valid). It is reused by other arbiters.

Test Plan:
- Single requester: NREQ=4, req1 writes 0xDEADBEEF @5 (wstrb 0xF), then reads @5 → s_resp_valid[1] 1 cycle after each accept, read rdata=0xDEADBEEF. s_resp_valid[0,2,3] stay 0.
- Round-robin fairness: all 4 valid continuously, resp_ready=1 → grant order 0,1,2,3,0,1,... Each requester gets 25 of 100 grants exactly.
- Lock burst: MAX_BURST=4, req2 lock=1 with req0/req3 valid → 4 consecutive grants to req2, then req3, then req0.
- Response backpressure: req0 read outstanding, s_resp_ready[0]=0 for 5 cycles while req1 is valid → s_req_ready all 0. req1 is granted in the cycle resp0 fires. resp1 is routed to owner 1.
- Reset mid-burst: LOCKED on req1 with beat_cnt=2, rst_n=0 for 1 cycle → lock_st=ARB, rr_ptr=0, all outputs 0. The next grant goes to the lowest valid index.
